// File: rtl/btn_pkg.sv
// Shared definitions for the button event generator: event codes, hold FSM
// state encoding and a small helper for sizing the hold counter.
package btn_pkg;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_REPEAT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RPT  = 2'd2
  } state_e;

  // Larger of two millisecond limits; the hold counter must reach either one.
  function automatic int max_ms(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_hold_fsm.sv
// Per-button hold tracker. Emits a one-cycle post (with its type) on press,
// release, and each auto-repeat point while the button stays held. The post
// is combinational so the top can store it on the same edge the edge is seen.
module btn_hold_fsm
  import btn_pkg::*;
#(
  parameter int HOLD_MS   = 500,
  parameter int REPEAT_MS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rise,
  input  logic       fall,
  output logic       post,
  output logic [1:0] post_type
);

  localparam int MS_MAX = max_ms(HOLD_MS, REPEAT_MS);
  localparam int MSW    = $clog2(MS_MAX + 1);

  state_e           state_q, state_d;
  logic [MSW-1:0]   ms_q, ms_d;
  logic [MSW-1:0]   ms_inc_s;

  // State and millisecond counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
    end
  end

  // Next state and posted event; a fall always beats a same-cycle timer hit.
  always_comb begin
    state_d   = state_q;
    ms_d      = ms_q;
    post      = 1'b0;
    post_type = EV_PRESS;
    ms_inc_s  = ms_q + MSW'(1);
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          post      = 1'b1;
          post_type = EV_PRESS;
          ms_d      = '0;
          state_d   = S_HOLD;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_HOLD: begin
        if (fall) begin
          post      = 1'b1;
          post_type = EV_RELEASE;
          ms_d      = '0;
          state_d   = S_IDLE;
        end else if (tick) begin
          if (ms_inc_s == MSW'(HOLD_MS)) begin
            post      = 1'b1;
            post_type = EV_REPEAT;
            ms_d      = '0;
            state_d   = S_RPT;
          end else begin
            ms_d      = ms_inc_s;
          end
        end else begin
          ms_d = ms_q;
        end
      end
      S_RPT: begin
        if (fall) begin
          post      = 1'b1;
          post_type = EV_RELEASE;
          ms_d      = '0;
          state_d   = S_IDLE;
        end else if (tick) begin
          if (ms_inc_s == MSW'(REPEAT_MS)) begin
            post      = 1'b1;
            post_type = EV_REPEAT;
            ms_d      = '0;
          end else begin
            ms_d      = ms_inc_s;
          end
        end else begin
          ms_d = ms_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        ms_d    = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_event_gen.sv
// Turns debounced button levels into press/release/repeat events delivered
// one at a time over valid/ready. Contains the 1 ms tick divider, edge
// detect, one pending slot per button, lowest-index pick and output register.
module button_event_gen
  import btn_pkg::*;
#(
  parameter int  NUM_BUTTONS = 4,
  parameter int  CLK_DIV     = 50000,
  parameter int  HOLD_MS     = 500,
  parameter int  REPEAT_MS   = 100,
  localparam int BW          = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_level,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [BW-1:0]          event_btn,
  output logic [1:0]             event_type,
  output logic [NUM_BUTTONS-1:0] held,
  output logic                   overflow
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         tick_s;
  logic [NUM_BUTTONS-1:0]       held_q, held_d;
  logic [NUM_BUTTONS-1:0]       rise_s, fall_s;
  logic [NUM_BUTTONS-1:0]       post_s;
  logic [NUM_BUTTONS-1:0][1:0]  post_type_s;
  logic [NUM_BUTTONS-1:0]       pend_v_q, pend_v_d;
  logic [NUM_BUTTONS-1:0][1:0]  pend_t_q, pend_t_d;
  logic                         valid_q, valid_d;
  logic [BW-1:0]                btn_q, btn_d;
  logic [1:0]                   type_q, type_d;
  logic                         ovf_q, ovf_d;
  logic                         load_s;
  logic                         any_s;
  logic                         found_s;
  logic [BW-1:0]                pick_s;
  logic [NUM_BUTTONS-1:0]       drain_s;

  // Free-running ms divider; tick is a clock enable, not a clock.
  always_comb begin
    tick_s = (cnt_q == CW'(CLK_DIV - 1));
    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Edge detect against the previous level, which doubles as the held output.
  always_comb begin
    held_d = btn_level;
    rise_s = btn_level & ~held_q;
    fall_s = ~btn_level & held_q;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_BUTTONS; g++) begin : gen_fsm
      btn_hold_fsm #(
        .HOLD_MS   (HOLD_MS),
        .REPEAT_MS (REPEAT_MS)
      ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick_s),
        .rise      (rise_s[g]),
        .fall      (fall_s[g]),
        .post      (post_s[g]),
        .post_type (post_type_s[g])
      );
    end
  endgenerate

  // Lowest-index pending slot wins the output register.
  always_comb begin
    any_s   = |pend_v_q;
    pick_s  = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      pick_s  = (pend_v_q[i] && !found_s) ? BW'(i) : pick_s;
      found_s = found_s | pend_v_q[i];
    end
  end

  // Output register load: refill whenever empty or the current event is taken.
  always_comb begin
    load_s  = !valid_q || event_ready;
    valid_d = valid_q;
    btn_d   = btn_q;
    type_d  = type_q;
    drain_s = '0;
    if (load_s) begin
      valid_d = any_s;
      if (any_s) begin
        btn_d           = pick_s;
        type_d          = pend_t_q[pick_s];
        drain_s[pick_s] = 1'b1;
      end else begin
        btn_d  = btn_q;
        type_d = type_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Pending slots: a new post wins over a same-cycle drain; overwriting an
  // undrained entry is the only way overflow gets set.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      pend_v_d[i] = post_s[i] | (pend_v_q[i] & ~drain_s[i]);
      pend_t_d[i] = post_s[i] ? post_type_s[i] : pend_t_q[i];
      ovf_d       = ovf_d | (post_s[i] & pend_v_q[i] & ~drain_s[i]);
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      held_q   <= '0;
      pend_v_q <= '0;
      pend_t_q <= '0;
      valid_q  <= 1'b0;
      btn_q    <= '0;
      type_q   <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      held_q   <= held_d;
      pend_v_q <= pend_v_d;
      pend_t_q <= pend_t_d;
      valid_q  <= valid_d;
      btn_q    <= btn_d;
      type_q   <= type_d;
      ovf_q    <= ovf_d;
    end
  end

  assign event_valid = valid_q;
  assign event_btn   = btn_q;
  assign event_type  = type_q;
  assign held        = held_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: a behavioural model (ticks counted since press,
// per-button mailbox, lowest-index delivery) checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_button_event_gen;

  localparam int NB = 4;
  localparam int CD = 10;
  localparam int HM = 5;
  localparam int RM = 2;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_level;
  logic          event_valid;
  logic          event_ready;
  logic [BW-1:0] event_btn;
  logic [1:0]    event_type;
  logic [NB-1:0] held;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  button_event_gen #(
    .NUM_BUTTONS (NB),
    .CLK_DIV     (CD),
    .HOLD_MS     (HM),
    .REPEAT_MS   (RM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_level   (btn_level),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_btn   (event_btn),
    .event_type  (event_type),
    .held        (held),
    .overflow    (overflow)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int          m_tcnt;
  bit [NB-1:0] m_held;
  bit          m_pressed [NB];
  int          m_ticks   [NB];
  bit          m_pv      [NB];
  int          m_pt      [NB];
  bit          m_valid;
  int          m_btn;
  int          m_type;
  bit          m_ovf;

  // Model update on every active edge from the inputs seen at that edge.
  always @(posedge clk) begin : model
    bit tick;
    bit post   [NB];
    int post_t [NB];
    int dr;
    if (reset) begin
      m_tcnt = 0; m_held = '0; m_valid = 1'b0; m_btn = 0; m_type = 0; m_ovf = 1'b0;
      for (int b = 0; b < NB; b++) begin
        m_pressed[b] = 1'b0; m_ticks[b] = 0; m_pv[b] = 1'b0; m_pt[b] = 0;
      end
    end else begin
      tick   = (m_tcnt == CD - 1);
      m_tcnt = (m_tcnt + 1) % CD;
      for (int b = 0; b < NB; b++) begin
        post[b] = 1'b0; post_t[b] = 0;
        if (btn_level[b] && !m_held[b]) begin
          m_pressed[b] = 1'b1; m_ticks[b] = 0; post[b] = 1'b1; post_t[b] = 0;
        end else if (!btn_level[b] && m_held[b]) begin
          m_pressed[b] = 1'b0; post[b] = 1'b1; post_t[b] = 1;
        end else if (m_pressed[b] && tick) begin
          m_ticks[b]++;
          if (m_ticks[b] >= HM && ((m_ticks[b] - HM) % RM) == 0) begin
            post[b] = 1'b1; post_t[b] = 2;
          end
        end
      end
      dr = -1;
      if (!m_valid || event_ready) begin
        m_valid = 1'b0;
        for (int b = 0; b < NB; b++) if (dr < 0 && m_pv[b]) dr = b;
        if (dr >= 0) begin
          m_valid = 1'b1; m_btn = dr; m_type = m_pt[dr]; m_pv[dr] = 1'b0;
        end
      end
      for (int b = 0; b < NB; b++) begin
        if (post[b]) begin
          if (m_pv[b]) m_ovf = 1'b1;
          m_pv[b] = 1'b1; m_pt[b] = post_t[b];
        end
      end
      m_held = btn_level;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", int'(event_valid), int'(m_valid));
      chk("held", int'(held), int'(m_held));
      chk("overflow", int'(overflow), int'(m_ovf));
      if (m_valid) begin
        chk("btn", int'(event_btn), m_btn);
        chk("type", int'(event_type), m_type);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int press_c;
    int cnt;
    int first;
    int gap;
    int rpt_q[$];
    logic [BW-1:0] sb;
    logic [1:0]    st;

    reset = 1'b1; btn_level = '0; event_ready = 1'b1;
    step(3);
    chk_en = 1'b1;
    chk("rst_valid", int'(event_valid), 0);
    chk("rst_held", int'(held), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset = 1'b0;
    step(2);

    // 1: short press on btn 2
    btn_level[2] = 1'b1;
    step(2);
    chk("t1_press_v", int'(event_valid), 1);
    chk("t1_press_b", int'(event_btn), 2);
    chk("t1_press_t", int'(event_type), 0);
    cnt = 0;
    for (int c = 0; c < 27; c++) begin
      step(1);
      if (event_valid) cnt++;
    end
    chk("t1_no_rpt", cnt, 0);
    btn_level[2] = 1'b0;
    step(2);
    chk("t1_rel_v", int'(event_valid), 1);
    chk("t1_rel_b", int'(event_btn), 2);
    chk("t1_rel_t", int'(event_type), 1);
    chk("t1_ovf", int'(overflow), 0);
    step(10);

    // 2: long hold on btn 0
    btn_level[0] = 1'b1;
    press_c = -1;
    for (int c = 0; c < 120; c++) begin
      step(1);
      if (event_valid && event_type == 2'd0 && event_btn == 2'd0) press_c = c;
      if (event_valid && event_type == 2'd2) rpt_q.push_back(c);
    end
    first = (rpt_q.size() > 0) ? rpt_q[0] - press_c : -1;
    gap   = (rpt_q.size() > 1) ? rpt_q[1] - rpt_q[0] : -1;
    chk("t2_press_at", press_c, 1);
    chk_rng("t2_first_rpt", first, 40, 50);
    chk("t2_rpt_gap", gap, 20);
    btn_level[0] = 1'b0;
    step(2);
    chk("t2_rel_b", int'(event_btn), 0);
    chk("t2_rel_t", int'(event_type), 1);
    step(5);

    // 3: simultaneous presses, lower index first
    btn_level[1] = 1'b1; btn_level[3] = 1'b1;
    step(2);
    chk("t3_first_b", int'(event_btn), 1);
    chk("t3_first_t", int'(event_type), 0);
    step(1);
    chk("t3_second_v", int'(event_valid), 1);
    chk("t3_second_b", int'(event_btn), 3);
    btn_level[1] = 1'b0; btn_level[3] = 1'b0;
    step(5);

    // 4: back-pressure holds the presented event stable
    event_ready = 1'b0;
    btn_level[0] = 1'b1;
    step(2);
    sb = event_btn; st = event_type;
    chk("t4_v", int'(event_valid), 1);
    chk("t4_b", int'(sb), 0);
    for (int c = 0; c < 30; c++) begin
      step(1);
      chk("t4_hold_v", int'(event_valid), 1);
      chk("t4_hold_b", int'(event_btn), int'(sb));
      chk("t4_hold_t", int'(event_type), int'(st));
    end
    event_ready = 1'b1;
    step(1);
    chk("t4_accept", int'(event_valid), 0);
    btn_level[0] = 1'b0;
    step(5);

    // 5: overwrite of a pending PRESS by RELEASE on btn 1
    event_ready = 1'b0;
    btn_level[0] = 1'b1;
    step(3);
    btn_level[1] = 1'b1;
    step(2);
    btn_level[1] = 1'b0;
    step(2);
    chk("t5_ovf", int'(overflow), 1);
    event_ready = 1'b1;
    step(10);
    chk("t5_ovf_sticky", int'(overflow), 1);

    // 6: reset while btn 0 is in repeat phase
    step(70);
    reset = 1'b1;
    step(1);
    chk("t6_rst_v", int'(event_valid), 0);
    chk("t6_rst_ovf", int'(overflow), 0);
    chk("t6_rst_held", int'(held), 0);
    reset = 1'b0;
    step(2);
    chk("t6_press_v", int'(event_valid), 1);
    chk("t6_press_b", int'(event_btn), 0);
    chk("t6_press_t", int'(event_type), 0);

    // randomized phase
    for (int c = 0; c < 8000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 99) == 0) btn_level[b] = ~btn_level[b];
      end
      event_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 2999) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
